// File: rtl/addr_data_sweep_gen_if.sv
// Handshake/bus bundle for addr_data_sweep_gen: control inputs, sweep parameters and the beat channel.
interface addr_data_sweep_gen_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) ();
  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] addr_lo;
  logic [ADDR_W-1:0] addr_hi;
  logic [DATA_W-1:0] data_seed;
  logic              out_ready;
  logic              out_valid;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic              done;

  modport master (
    input  start, abort, mode, addr_lo, addr_hi, data_seed, out_ready,
    output out_valid, addr, data, busy, done
  );

  modport slave (
    output start, abort, mode, addr_lo, addr_hi, data_seed, out_ready,
    input  out_valid, addr, data, busy, done
  );
endinterface

// File: rtl/addr_data_sweep_gen.sv
// Address/data sweep generator over [addr_lo..addr_hi] with selectable data patterns.
// Macro ADDR_DATA_SWEEP_WRAP_EN: restart at addr_lo after the last beat instead of finishing.
module addr_data_sweep_gen #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  addr_data_sweep_gen_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {M_INC, M_CONST, M_WALK1, M_INVINC} mode_t;

  state_t            state_q, state_d;
  mode_t             mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef ADDR_DATA_SWEEP_WRAP_EN
  logic [ADDR_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] seed_q, seed_d;
`endif
  logic [DATA_W-1:0] seed_eff;

  function automatic logic [DATA_W-1:0] step_data(input logic [DATA_W-1:0] d, input mode_t m);
    logic [DATA_W-1:0] r;
    case (m)
      M_INC:    r = d + 1'b1;
      M_CONST:  r = d;
      M_WALK1:  r = {d[DATA_W-2:0], d[DATA_W-1]};
      default:  r = ~d + 1'b1;
    endcase
    return r;
  endfunction

  // WALK1 from an all-zero seed would never show a bit, so it starts from 1.
  always_comb begin
    seed_eff = bus.data_seed;
    if (mode_t'(bus.mode) == M_WALK1 && bus.data_seed == '0) seed_eff = {{(DATA_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef ADDR_DATA_SWEEP_WRAP_EN
    lo_d    = lo_q;
    seed_d  = seed_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          mode_d = mode_t'(bus.mode);
          hi_d   = bus.addr_hi;
`ifdef ADDR_DATA_SWEEP_WRAP_EN
          lo_d   = bus.addr_lo;
          seed_d = seed_eff;
`endif
          if (bus.addr_lo <= bus.addr_hi) begin
            state_d = S_RUN;
            addr_d  = bus.addr_lo;
            data_d  = seed_eff;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (valid_q && bus.out_ready) begin
          if (addr_q == hi_q) begin
`ifdef ADDR_DATA_SWEEP_WRAP_EN
            addr_d  = lo_q;
            data_d  = seed_q;
`else
            state_d = S_DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
          end else begin
            addr_d = addr_q + 1'b1;
            data_d = step_data(data_q, mode_q);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= M_INC;
      addr_q  <= '0;
      hi_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef ADDR_DATA_SWEEP_WRAP_EN
      lo_q    <= '0;
      seed_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef ADDR_DATA_SWEEP_WRAP_EN
      lo_q    <= lo_d;
      seed_q  <= seed_d;
`endif
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.addr      = addr_q;
  assign bus.data      = data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_addr_data_sweep_gen.sv
// Randomised self-checking bench for addr_data_sweep_gen against a closed-form beat model.
module tb_addr_data_sweep_gen;
  localparam int AW   = 4;
  localparam int DW   = 4;
  localparam int DMSK = (1 << DW) - 1;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  addr_data_sweep_gen_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  addr_data_sweep_gen #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Data word of beat i, straight from the pattern definitions.
  function automatic int exp_data(input int mode, input int seed, input int i);
    int d0;
    int r;
    d0 = (mode == 2 && seed == 0) ? 1 : seed;
    case (mode)
      0: return (d0 + i) & DMSK;
      1: return d0;
      2: begin
        r = i % DW;
        return ((d0 << r) | (d0 >> (DW - r))) & DMSK;
      end
      default: return (i % 2 == 1) ? ((16 - d0) & DMSK) : d0;
    endcase
  endfunction

  task automatic scramble_inputs();
    bus.mode      = 2'($urandom_range(0, 3));
    bus.addr_lo   = AW'($urandom_range(0, 15));
    bus.addr_hi   = AW'($urandom_range(0, 15));
    bus.data_seed = DW'($urandom_range(0, 15));
  endtask

  // abort_at: beat index at which abort is raised, or -1 for none.
  task automatic run_sweep(input int mode, input int lo, input int hi, input int seed, input int abort_at);
    int n;
    int beats;
    int idx;
    int cycles;
    int ab_at;
    bit rdy;
    bit ab;
    bus.mode      = 2'(mode);
    bus.addr_lo   = AW'(lo);
    bus.addr_hi   = AW'(hi);
    bus.data_seed = DW'(seed);
    bus.start     = 1'b1;
    step();
    bus.start = 1'b0;
    scramble_inputs();
    if (lo > hi) begin
      chk("empty_valid", bus.out_valid, 1'b0);
      chk("empty_busy", bus.busy, 1'b0);
      chk("empty_done", bus.done, 1'b1);
      step();
      chk("empty_done_end", bus.done, 1'b0);
      chk("empty_valid_end", bus.out_valid, 1'b0);
      return;
    end
    n      = hi - lo + 1;
    beats  = 0;
    cycles = 0;
    ab_at  = abort_at;
`ifdef ADDR_DATA_SWEEP_WRAP_EN
    if (ab_at < 0) ab_at = n + $urandom_range(1, 2 * n + 2);
`endif
    forever begin
      idx = beats % n;
      chk("run_valid", bus.out_valid, 1'b1);
      chk("run_busy", bus.busy, 1'b1);
      chk("run_done", bus.done, 1'b0);
      chk("beat_addr", bus.addr, 32'(lo + idx));
      chk("beat_data", bus.data, 32'(exp_data(mode, seed, idx)));
      ab  = (beats == ab_at) && ($urandom_range(0, 1) == 1);
      rdy = ab ? 1'b1 : ($urandom_range(0, 2) != 0);
      bus.out_ready = rdy;
      bus.abort     = ab;
      bus.start     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) scramble_inputs();
      step();
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (ab) begin
        chk("abort_valid", bus.out_valid, 1'b0);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_addr", bus.addr, 32'(lo + idx));
        chk("abort_data", bus.data, 32'(exp_data(mode, seed, idx)));
        step();
        chk("abort_idle_done", bus.done, 1'b0);
        chk("abort_idle_valid", bus.out_valid, 1'b0);
        return;
      end
      if (rdy) beats++;
`ifndef ADDR_DATA_SWEEP_WRAP_EN
      if (beats == n) begin
        chk("end_valid", bus.out_valid, 1'b0);
        chk("end_busy", bus.busy, 1'b0);
        chk("end_done", bus.done, 1'b1);
        step();
        chk("end_done_pulse", bus.done, 1'b0);
        chk("end_idle_valid", bus.out_valid, 1'b0);
        return;
      end
`endif
      cycles++;
      if (cycles > 500) begin
        chk("sweep_timeout", 1'b1, 1'b0);
        return;
      end
    end
  endtask

  initial begin
    int lo;
    int hi;
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.out_ready = 1'b0;
    scramble_inputs();
    #3;
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_addr", bus.addr, 32'h0);
    chk("rst_data", bus.data, 32'h0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    #9 rst_n = 1'b1;
    step();

    // start together with abort in IDLE must be ignored
    bus.addr_lo = 4'd1; bus.addr_hi = 4'd3; bus.start = 1'b1; bus.abort = 1'b1;
    step();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_abort_valid", bus.out_valid, 1'b0);
    chk("start_abort_busy", bus.busy, 1'b0);
    chk("start_abort_done", bus.done, 1'b0);
    step();

    run_sweep(0, 2, 5, 9, -1);
    run_sweep(2, 0, 4, 0, -1);
    run_sweep(3, 0, 2, 3, -1);
    run_sweep(1, 6, 6, 5, -1);
    run_sweep(0, 7, 3, 1, -1);
    run_sweep(0, 3, 9, 4, 2);
    run_sweep(2, 0, 15, 6, -1);
    run_sweep(3, 0, 15, 11, -1);
    for (int unsigned k = 0; k < 40; k++) begin
      lo = $urandom_range(0, 15);
      hi = $urandom_range(0, 15);
      run_sweep($urandom_range(0, 3), lo, hi, $urandom_range(0, 15),
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1);
      repeat ($urandom_range(0, 2)) step();
    end

    // asynchronous reset in the middle of a sweep, at addr 5
    bus.mode = 2'd0; bus.addr_lo = 4'd0; bus.addr_hi = 4'd10; bus.data_seed = 4'd7;
    bus.out_ready = 1'b1; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (5) step();
    chk("pre_rst_addr", bus.addr, 32'h5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", bus.out_valid, 1'b0);
    chk("async_rst_addr", bus.addr, 32'h0);
    chk("async_rst_data", bus.data, 32'h0);
    chk("async_rst_busy", bus.busy, 1'b0);
    chk("async_rst_done", bus.done, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", bus.out_valid, 1'b0);
    chk("post_rst_busy", bus.busy, 1'b0);
    chk("post_rst_done", bus.done, 1'b0);
    run_sweep(0, 14, 15, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
